// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the loadable up- and down-counters.
//   state_t       : two-state controller encoding (IDLE / COUNT)
//   DEFAULT_WIDTH : default counter width used by both counters
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

endpackage : counter_pkg

// File: rtl/sync_loadable_down_counter.sv
// -----------------------------------------------------------------------------
// sync_loadable_down_counter
// Loadable down-counter / interval timer. A load captures the start value into
// both the count and the reload register. While counting, each enabled cycle
// decrements the count. When the count steps off 1 a one-cycle terminal-count
// pulse is raised. The counter then either reloads (periodic tick) or stops at
// zero and returns to idle.
//
// Ports
//   clk          : system clock, all state changes on the rising edge
//   rst          : synchronous active-high reset (overrides load and en)
//   load         : capture din into count and reload register
//   din          : start / reload value
//   en           : count enable, only honoured while counting
//   auto_reload  : at terminal count, 1 = reload from reload register, 0 = stop
//   dout         : current count (registered)
//   busy         : high while counting (registered)
//   tc           : terminal-count pulse, one cycle (registered)
// -----------------------------------------------------------------------------
module sync_loadable_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_busy;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_reload_next;
  logic             w_tc_next;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= ZERO;
      r_reload <= ZERO;
      r_tc     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_reload <= w_reload_next;
      r_tc     <= w_tc_next;
      // busy tracks the state it is registered alongside.
      r_busy   <= (w_state_next == ST_COUNT);
    end
  end

  // Next-state and datapath logic. Load takes priority over counting.
  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_reload_next = r_reload;
    w_tc_next     = 1'b0;

    if (load) begin
      w_count_next  = din;
      w_reload_next = din;
      // A zero start value has nothing to count, so it never enters COUNT.
      w_state_next  = (din != ZERO) ? ST_COUNT : ST_IDLE;
    end else if ((r_state == ST_COUNT) && en) begin
      if (r_count == ONE) begin
        w_tc_next = 1'b1;
        if (auto_reload) begin
          w_count_next = r_reload;
        end else begin
          w_count_next = ZERO;
          w_state_next = ST_IDLE;
        end
      end else if (r_count == ZERO) begin
        // Unreachable in normal operation; park safely rather than wrap.
        w_state_next = ST_IDLE;
      end else begin
        w_count_next = r_count - ONE;
      end
    end
  end

  assign dout = r_count;
  assign busy = r_busy;
  assign tc   = r_tc;

endmodule : sync_loadable_down_counter

// File: tb/tb_sync_loadable_down_counter.sv
// -----------------------------------------------------------------------------
// tb_sync_loadable_down_counter
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural timer model (remaining ticks, reload value, running flag).
// -----------------------------------------------------------------------------
module tb_sync_loadable_down_counter;

  localparam int W   = 4;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         en = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] dout;
  logic         busy;
  logic         tc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tc_seen = 0;

  // Reference model state
  int remaining = 0;
  int period    = 0;
  bit running   = 1'b0;
  bit pulse     = 1'b0;

  sync_loadable_down_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .din         (din),
    .en          (en),
    .auto_reload (auto_reload),
    .dout        (dout),
    .busy        (busy),
    .tc          (tc)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Timer behaviour: on reset everything clears; a load restarts the timer
  // with a new interval; an enabled running timer consumes one tick and, when
  // the last tick is consumed, pulses and either restarts or stops at 0.
  task automatic model_step(input bit r, input bit l, input int d, input bit e, input bit a);
    pulse = 1'b0;
    if (r) begin
      remaining = 0;
      period    = 0;
      running   = 1'b0;
    end else if (l) begin
      remaining = d % (MAX + 1);
      period    = remaining;
      running   = (remaining > 0);
    end else if (running && e) begin
      remaining = remaining - 1;
      if (remaining == 0) begin
        pulse = 1'b1;
        if (a) remaining = period;
        else   running   = 1'b0;
      end
    end
  endtask

  // One transaction: drive on negedge, sample 1 time unit after the posedge.
  task automatic cycle(input bit r, input bit l, input int d, input bit e, input bit a);
    @(negedge clk);
    rst = r; load = l; din = W'(d); en = e; auto_reload = a;
    model_step(r, l, d, e, a);
    @(posedge clk);
    #1;
    cyc++;
    if (tc === 1'b1) tc_seen++;
    $display("cyc %0d rst=%0b load=%0b din=%0d en=%0b ar=%0b -> dout=%0d busy=%0b tc=%0b",
             cyc, r, l, d, e, a, dout, busy, tc);
    check("dout", 32'(dout), 32'(remaining));
    check("busy", 32'(busy), 32'(running));
    check("tc",   32'(tc),   32'(pulse));
  endtask

  initial begin
    int exp_ar [6];
    int tc_at;

    // Reset with a simultaneous load: the load must be ignored.
    cycle(1, 1, 5, 0, 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tc",   32'(tc),   0);

    // One-shot 3: 3,2,1,0 with tc only on 0, then hold at 0.
    tc_seen = 0;
    cycle(0, 1, 3, 1, 0);
    check("oneshot_load", 32'(dout), 3);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    check("oneshot_end_dout", 32'(dout), 0);
    check("oneshot_end_tc",   32'(tc),   1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
    check("oneshot_hold_dout", 32'(dout), 0);
    check("oneshot_tc_count",  32'(tc_seen), 1);

    // Auto-reload 2 with en gating 1,0,1,1,1.
    exp_ar = '{2, 1, 1, 2, 1, 2};
    tc_seen = 0;
    cycle(0, 1, 2, 0, 1);
    check("ar_dout0", 32'(dout), 32'(exp_ar[0]));
    begin
      bit ens [5];
      ens = '{1, 0, 1, 1, 1};
      for (int i = 0; i < 5; i++) begin
        cycle(0, 0, 0, ens[i], 1);
        check("ar_dout", 32'(dout), 32'(exp_ar[i+1]));
      end
    end
    check("ar_tc_count", 32'(tc_seen), 2);

    // Mid-count reload, then a load that coincides with the terminal step.
    tc_seen = 0;
    cycle(0, 1, 10, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    check("mid_dout7", 32'(dout), 7);
    cycle(0, 1, 3, 1, 0);
    check("mid_reload", 32'(dout), 3);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("mid_at_one", 32'(dout), 1);
    cycle(0, 1, 5, 1, 0);
    check("coincide_dout", 32'(dout), 5);
    check("coincide_tc",   32'(tc),   0);
    check("mid_no_tc",     32'(tc_seen), 0);

    // Reset mid-count.
    cycle(1, 0, 0, 1, 0);
    check("rst_mid_dout", 32'(dout), 0);
    check("rst_mid_busy", 32'(busy), 0);

    // Zero load: stays idle, never pulses.
    tc_seen = 0;
    cycle(0, 1, 0, 1, 1);
    check("zero_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
    check("zero_no_tc", 32'(tc_seen), 0);

    // Full range 15, one-shot: tc after exactly 15 enabled edges, no wrap.
    tc_at = -1;
    cycle(0, 1, MAX, 1, 0);
    for (int i = 1; i <= MAX + 3; i++) begin
      cycle(0, 0, 0, 1, 0);
      if (tc === 1'b1 && tc_at < 0) tc_at = i;
    end
    check("max_tc_edge", 32'(tc_at), 32'(MAX));
    check("max_no_wrap", 32'(dout), 0);

    // Reload value 1 with auto-reload: tc every enabled cycle, dout stays 1.
    tc_seen = 0;
    cycle(0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
    check("one_ar_dout", 32'(dout), 1);
    check("one_ar_tc",   32'(tc_seen), 4);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, MAX)),
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_loadable_down_counter
